fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  MIPS instruction-fetch stage: owns the program counter and drives the instruction-memory
//  address. Reads the combinational instruction word back in the same cycle and registers
//  instr/PC into the IF/ID output register for decode. Uses a valid/ready handshake and
//  accepts branch/jump redirects resolved in decode.
// PARAMETERS
//  RESET_PC   32'h00000000  PC loaded on reset; must be word-aligned
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   synchronous, active-high reset
//  imem_addr       out  32  instruction-memory byte address (= pc, combinational from pc reg)
//  imem_rdata      in   32  instruction word for imem_addr, valid same cycle
//  fetch_en        in   1   1 = fetch allowed; 0 = no new capture, pc held
//  id_valid        out  1   IF/ID register holds a valid instruction
//  id_ready        in   1   decode accepts IF/ID contents this cycle
//  id_instr        out  32  registered instruction word
//  id_pc           out  32  byte address of id_instr
//  id_pc_plus4     out  32  id_pc + 4 (mod 2^32)
//  redirect_valid  in   1   decode takes a branch/jump this cycle
//  redirect_pc     in   32  target byte address; bits [1:0] ignored (treated as 00)
// BEHAVIOUR
//  - Reset: pc<=RESET_PC; id_valid<=0; id_instr, id_pc, id_pc_plus4 <=0. Reset wins over all inputs.
//  - Transfer: xfer = id_valid & id_ready. Load condition: load = fetch_en & (~id_valid | id_ready).
//  - On load: id_instr<=imem_rdata, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
//  - xfer without load: id_valid<=0; outputs otherwise hold.
//  - Neither: all state holds. Stall is lossless; id_* are stable while id_valid & ~id_ready.
//  - Latency: instruction at pc appears on id_* one cycle after capture.
//    Throughput: 1 instr/cycle when id_ready=1.
//  - pc increments modulo 2^32: 32'hFFFFFFFC -> 32'h00000000. No trap.
//  - Redirect: legal only when xfer=1, i.e. the branch is in IF/ID and consumed.
//    Redirect without xfer is a protocol error: ignored, with a simulation assertion.
//  - Redirect priority: redirect_valid overrides pc+4; pc<={redirect_pc[31:2],2'b00}.
//    The fetch at the old pc is handled per CONFIGURATION.
//  - redirect and ~fetch_en together: pc still redirected, no capture, id_valid<=0.
//  - Reset mid-stall or mid-redirect: all in-flight state discarded; fetch restarts at RESET_PC.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN defined: on redirect the word at old pc (delay slot) is still captured
//   into IF/ID if load=1. pc<=target, so decode sees branch, slot, then target.
//  BRANCH_DELAY_SLOT_EN undefined: on redirect the word at old pc is discarded.
//   id_valid<=0, pc<=target, so decode sees branch, one bubble, then target.
// STRUCTURE
//  Shared package mips_pkg:
//   constants INSTR_NOP=32'h0, XLEN=32, RESET_PC default.
//   typedef if_id_t {instr, pc, pc_plus4}.
//  One sub-module: if_id_reg. It holds the payload + valid and implements the load/xfer hold rules.
//  The pc register and next-pc mux stay in fetch_stage.
// TESTING (bench instantiates the team's instruction ROM on imem_addr/imem_rdata)
//  1 Reset, fetch_en=1, id_ready=1:
//    id_valid=1 from cycle 1.
//    id: (0x0,0x00000000), (0x4,0x20080004), (0x8,0x2009000D), (0xC,0x01095020).
//  2 Hold id_ready=0 while id_pc=0x8 for 3 cycles:
//    id_instr stays 0x2009000D; pc stays 0xC.
//    Release gives 0x01095020 next with no gaps or duplicates.
//  3 Delay slot off, redirect_pc=0x18 while id_pc=0x38:
//    one cycle id_valid=0, then id_pc=0x18, id_instr=0x200CBABE.
//  4 BRANCH_DELAY_SLOT_EN, same redirect:
//    id_pc=0x3C (0x00000000), then id_pc=0x18 (0x200CBABE).
//  5 Wrap: RESET_PC=32'hFFFFFFF8 -> id_pc FFFFFFF8, FFFFFFFC, 00000000; id_pc_plus4 of FFFFFFFC = 0.
//  6 rst=1 for 1 cycle while stalled at id_pc=0x10:
//    next cycle id_valid=0, pc=0; then id_pc=0x0.
//  6 Redirect with id_ready=0: assertion fires and pc is unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants.
// Imported by fetch_stage and if_id_reg.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: payload plus valid flag.
// Captures on load, drains to empty on transfer, otherwise holds.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   xfer,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  // Load wins over drain; stall keeps payload stable
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: pc register, next-pc mux, IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot word on redirect.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        fetch_en,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target;
  logic            xfer;
  logic            load;
  logic            redir;
  logic            cap;
  logic            unused_lsb;
  if_id_t          d;
  if_id_t          q;

  assign unused_lsb = ^redirect_pc[1:0];

  assign xfer   = id_valid & id_ready;
  assign load   = fetch_en & (~id_valid | id_ready);
  assign redir  = redirect_valid & xfer;
  assign pc_inc = pc + 32'd4;
  assign target = {redirect_pc[31:2], 2'b00};

`ifdef BRANCH_DELAY_SLOT_EN
  assign cap = load;
`else
  assign cap = load & ~redir;
`endif

  // Redirect beats sequential advance; pc holds without a capture
  always_comb begin
    pc_next = pc;
    if (redir)
      pc_next = target;
    else if (cap)
      pc_next = pc_inc;
  end

  // Program counter register
  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  // Redirect is only meaningful when the branch leaves IF/ID
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(redirect_valid && !xfer))
        else $warning("fetch_stage: redirect without transfer ignored");
  end

  assign d.instr    = imem_rdata;
  assign d.pc       = pc;
  assign d.pc_plus4 = pc_inc;

  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (cap),
    .xfer  (xfer),
    .d     (d),
    .valid (id_valid),
    .q     (q)
  );

  assign imem_addr   = pc;
  assign id_instr    = q.instr;
  assign id_pc       = q.pc;
  assign id_pc_plus4 = q.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction ROM model.
// Second instance exercises pc wrap from 32'hFFFFFFF8.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  logic        w_en = 1'b1;
  logic        w_rdy = 1'b1;
  logic        w_rv = 1'b0;
  logic [31:0] w_rpc = 32'h0;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_plus4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00: rom = 32'h0000_0000;
      32'h04: rom = 32'h2008_0004;
      32'h08: rom = 32'h2009_000D;
      32'h0C: rom = 32'h0109_5020;
      32'h18: rom = 32'h200C_BABE;
      32'h38: rom = 32'h1000_FFF7;
      32'h3C: rom = 32'h0000_0000;
      default: rom = 32'h2400_0000 | a;
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);
  assign w_rdata    = rom(w_addr);

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .fetch_en       (fetch_en),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (w_addr),
    .imem_rdata     (w_rdata),
    .fetch_en       (w_en),
    .id_valid       (w_valid),
    .id_ready       (w_rdy),
    .id_instr       (w_instr),
    .id_pc          (w_pc),
    .id_pc_plus4    (w_plus4),
    .redirect_valid (w_rv),
    .redirect_pc    (w_rpc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    step;
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc", imem_addr, 32'h0);
    check("rst_wpc", w_addr, 32'hFFFF_FFF8);
    rst = 1'b0;

    step;
    check("f0_valid", {31'd0, id_valid}, 32'd1);
    check("f0_pc", id_pc, 32'h0);
    check("f0_instr", id_instr, 32'h0);
    check("f0_plus4", id_pc_plus4, 32'h4);
    check("w0_pc", w_pc, 32'hFFFF_FFF8);

    step;
    check("f1_pc", id_pc, 32'h4);
    check("f1_instr", id_instr, 32'h2008_0004);
    check("w1_pc", w_pc, 32'hFFFF_FFFC);
    check("w1_plus4", w_plus4, 32'h0);

    step;
    check("f2_pc", id_pc, 32'h8);
    check("f2_instr", id_instr, 32'h2009_000D);
    check("w2_pc", w_pc, 32'h0);
    id_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step;
      check("stall_pc", id_pc, 32'h8);
      check("stall_instr", id_instr, 32'h2009_000D);
      check("stall_valid", {31'd0, id_valid}, 32'd1);
      check("stall_fpc", imem_addr, 32'hC);
    end
    id_ready = 1'b1;

    step;
    check("rel_pc", id_pc, 32'hC);
    check("rel_instr", id_instr, 32'h0109_5020);
    step;
    check("rel_next", id_pc, 32'h10);

    for (int i = 0; i < 12; i++) begin
      if (id_pc == 32'h38) break;
      step;
    end
    check("reach_38", id_pc, 32'h38);

    redirect_valid = 1'b1;
    redirect_pc = 32'h1B;
    step;
    redirect_valid = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    check("slot_pc", id_pc, 32'h3C);
    check("slot_instr", id_instr, 32'h0);
    check("slot_valid", {31'd0, id_valid}, 32'd1);
    check("slot_fpc", imem_addr, 32'h18);
`else
    check("bub_valid", {31'd0, id_valid}, 32'd0);
    check("bub_fpc", imem_addr, 32'h18);
`endif
    step;
    check("tgt_pc", id_pc, 32'h18);
    check("tgt_instr", id_instr, 32'h200C_BABE);
    check("tgt_valid", {31'd0, id_valid}, 32'd1);

    fetch_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step;
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    check("nofe_valid", {31'd0, id_valid}, 32'd0);
    check("nofe_fpc", imem_addr, 32'h10);
    step;
    check("nofe_tgt", id_pc, 32'h10);

    id_ready = 1'b0;
    step;
    redirect_valid = 1'b1;
    redirect_pc = 32'h30;
    step;
    redirect_valid = 1'b0;
    check("bad_fpc", imem_addr, 32'h14);
    check("bad_id_pc", id_pc, 32'h10);
    check("bad_valid", {31'd0, id_valid}, 32'd1);

    rst = 1'b1;
    step;
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_fpc", imem_addr, 32'h0);
    rst = 1'b0;
    id_ready = 1'b1;
    step;
    check("mrst_id_pc", id_pc, 32'h0);
    check("mrst_v", {31'd0, id_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
